// File: rtl/ili9341_defines.sv
// ili9341_defines: shared ILI9341 opcodes, pixel format and peripheral FSM states
package ili9341_defines;
    typedef enum logic [7:0] {
        NOP     = 8'h00,
        SWRESET = 8'h01,
        CASET   = 8'h2A,
        PASET   = 8'h2B,
        RAMWR   = 8'h2C
    } ILI9341_register_t;

    typedef struct packed {
        logic [4:0] red;
        logic [5:0] green;
        logic [4:0] blue;
    } ILI9341_color_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PARAM,
        S_PIXEL_HI,
        S_PIXEL_LO,
        S_IGNORE
    } state_t;
endpackage

// File: rtl/spi_byte_deserializer.sv
// spi_byte_deserializer: synchronizes mode-0 SPI lines into clk and assembles MSB-first bytes
module spi_byte_deserializer (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_csb,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    input  logic       data_commandb,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_dc
);
    logic [1:0] csb_s, sck_s, mosi_s, dc_s;
    logic       sck_q;
    logic [2:0] bit_cnt;
    logic [6:0] shift;
    logic       sck_rise;

    assign sck_rise = sck_s[1] & ~sck_q;

    // Synchronizers keep tracking through reset so no stale edge fires on release
    always_ff @(posedge clk) begin
        csb_s  <= {csb_s[0], spi_csb};
        sck_s  <= {sck_s[0], spi_clk};
        mosi_s <= {mosi_s[0], spi_mosi};
        dc_s   <= {dc_s[0], data_commandb};
        sck_q  <= sck_s[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            byte_dc    <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (csb_s[1]) begin
                bit_cnt <= '0;
            end else if (sck_rise) begin
                shift   <= {shift[5:0], mosi_s[1]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    byte_data  <= {shift, mosi_s[1]};
                    byte_dc    <= dc_s[1];
                end
            end
        end
    end
endmodule

// File: rtl/ili9341_spi_peripheral.sv
// ili9341_spi_peripheral: ILI9341-style SPI command decoder writing RAMWR pixels into a frame buffer
module ili9341_spi_peripheral
    import ili9341_defines::*;
#(
    parameter int DISPLAY_WIDTH  = 240,
    parameter int DISPLAY_HEIGHT = 320,
    parameter int VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      display_rstb,
    input  logic                      spi_csb,
    input  logic                      spi_clk,
    input  logic                      spi_mosi,
    input  logic                      data_commandb,
    output logic                      spi_miso,
    output logic                      vram_wr_ena,
    output logic [$clog2(VRAM_L)-1:0] vram_wr_addr,
    output logic [15:0]               vram_wr_data,
    output logic                      cmd_valid,
    output logic [7:0]                cmd,
    output logic                      frame_done,
    output logic                      window_error
);
    localparam int AW = $clog2(VRAM_L);

    logic           srst;
    logic           byte_valid, byte_dc;
    logic [7:0]     byte_data;
    state_t         state;
    logic [15:0]    sc, ec, sp, ep, x, y;
    logic [1:0]     pidx;
    logic           is_page;
    logic [7:0]     p0, p1, p2, hi;
    logic [15:0]    new_s, raw_e, lim, new_e;
    ILI9341_color_t px;

    assign srst     = rst | ~display_rstb;
    assign spi_miso = 1'b0;
    assign new_s    = {p0, p1};
    assign raw_e    = {p2, byte_data};
    assign lim      = is_page ? 16'(DISPLAY_HEIGHT) : 16'(DISPLAY_WIDTH);
    assign new_e    = (raw_e >= lim) ? lim - 16'd1 : raw_e;
    assign px       = {hi, byte_data};

    spi_byte_deserializer u_deser (
        .clk          (clk),
        .rst          (srst),
        .spi_csb      (spi_csb),
        .spi_clk      (spi_clk),
        .spi_mosi     (spi_mosi),
        .data_commandb(data_commandb),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_dc      (byte_dc)
    );

    always_ff @(posedge clk) begin
        if (srst) begin
            state        <= S_IDLE;
            sc           <= '0;
            ec           <= 16'(DISPLAY_WIDTH - 1);
            sp           <= '0;
            ep           <= 16'(DISPLAY_HEIGHT - 1);
            x            <= '0;
            y            <= '0;
            pidx         <= '0;
            is_page      <= 1'b0;
            p0           <= '0;
            p1           <= '0;
            p2           <= '0;
            hi           <= '0;
            vram_wr_ena  <= 1'b0;
            vram_wr_addr <= '0;
            vram_wr_data <= '0;
            cmd_valid    <= 1'b0;
            cmd          <= '0;
            frame_done   <= 1'b0;
            window_error <= 1'b0;
        end else begin
            vram_wr_ena <= 1'b0;
            cmd_valid   <= 1'b0;
            frame_done  <= 1'b0;
            if (byte_valid && !byte_dc) begin
                cmd_valid <= 1'b1;
                cmd       <= byte_data;
                pidx      <= '0;
                if (byte_data == CASET || byte_data == PASET) begin
                    state   <= S_PARAM;
                    is_page <= (byte_data == PASET);
                end else if (byte_data == RAMWR) begin
                    state <= S_PIXEL_HI;
                    x     <= sc;
                    y     <= sp;
                end else if (byte_data == SWRESET) begin
                    state <= S_IDLE;
                    sc    <= '0;
                    ec    <= 16'(DISPLAY_WIDTH - 1);
                    sp    <= '0;
                    ep    <= 16'(DISPLAY_HEIGHT - 1);
                end else begin
                    state <= (byte_data == NOP) ? S_IDLE : S_IGNORE;
                end
            end else if (byte_valid) begin
                case (state)
                    S_PARAM: begin
                        pidx <= pidx + 2'd1;
                        if (pidx == 2'd0) p0 <= byte_data;
                        if (pidx == 2'd1) p1 <= byte_data;
                        if (pidx == 2'd2) p2 <= byte_data;
                        if (pidx == 2'd3) begin
                            state <= S_IDLE;
                            if (new_s > new_e) window_error <= 1'b1;
                            else if (is_page) begin
                                sp <= new_s;
                                ep <= new_e;
                            end else begin
                                sc <= new_s;
                                ec <= new_e;
                            end
                        end
                    end
                    S_PIXEL_HI: begin
                        hi    <= byte_data;
                        state <= S_PIXEL_LO;
                    end
                    S_PIXEL_LO: begin
                        state        <= S_PIXEL_HI;
                        vram_wr_ena  <= 1'b1;
                        vram_wr_addr <= AW'(32'(y) * DISPLAY_WIDTH + 32'(x));
                        vram_wr_data <= px;
                        // Raster-scan the window, wrapping back to its top-left corner
                        if (x == ec) begin
                            x <= sc;
                            if (y == ep) begin
                                y          <= sp;
                                frame_done <= 1'b1;
                            end else begin
                                y <= y + 16'd1;
                            end
                        end else begin
                            x <= x + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
